// File: rtl/timer_irq.sv
// Compare-match interrupt timer: one-shot or periodic events against a shared
// free-running count, with acknowledge, overrun tracking and wrap-safe compare.
module timer_irq #(
   parameter int unsigned time_size = 32
) (
   input  logic                 clk_clock,
   input  logic                 rst,
   input  logic [time_size-1:0] count,
   input  logic                 wr_en,
   input  logic [1:0]           wr_addr,
   input  logic [time_size-1:0] wr_data,
   input  logic                 irq_ack,
   output logic                 irq,
   output logic                 overrun,
   output logic                 armed,
   output logic [time_size-1:0] match_count
);

   localparam logic [1:0] ADDR_COMPARE = 2'd0;
   localparam logic [1:0] ADDR_PERIOD  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      PENDING = 2'd2
   } state_t;

   state_t               state;
   state_t               state_d;
   logic [time_size-1:0] compare_q;
   logic [time_size-1:0] period_q;
   logic                 enable_q;
   logic                 periodic_q;

   logic                 wr_compare_c;
   logic                 wr_period_c;
   logic                 wr_control_c;
   logic                 disable_c;
   logic                 ovr_clear_c;
   logic [time_size-1:0] delta_c;
   logic                 fire_c;
   logic                 advance_c;
   logic                 ovr_event_c;

   assign wr_compare_c = wr_en && (wr_addr == ADDR_COMPARE);
   assign wr_period_c  = wr_en && (wr_addr == ADDR_PERIOD);
   assign wr_control_c = wr_en && (wr_addr == ADDR_CONTROL);
   assign disable_c    = wr_control_c && !wr_data[0];
   assign ovr_clear_c  = wr_control_c && wr_data[2];

   // Reached-or-passed test: the difference is "non-negative" within half the range.
   assign delta_c   = count - compare_q;
   assign fire_c    = enable_q && (state != IDLE) && !delta_c[time_size-1] && !disable_c;
   assign advance_c = periodic_q && (period_q != '0);
   assign ovr_event_c = fire_c && (state == PENDING) && !irq_ack;

   // Next-state selection; a disabling CONTROL write beats everything else.
   always_comb begin
      state_d = state;
      case (state)
         IDLE: begin
            if (wr_control_c && wr_data[0]) state_d = ARMED;
         end
         ARMED: begin
            if (disable_c)   state_d = IDLE;
            else if (fire_c) state_d = PENDING;
         end
         PENDING: begin
            if (disable_c)    state_d = IDLE;
            else if (fire_c)  state_d = PENDING;
            else if (irq_ack) state_d = enable_q ? ARMED : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_clock) begin
      if (!rst) begin
         state       <= IDLE;
         irq         <= 1'b0;
         armed       <= 1'b0;
         overrun     <= 1'b0;
         match_count <= '0;
         compare_q   <= '0;
         period_q    <= '0;
         enable_q    <= 1'b0;
         periodic_q  <= 1'b0;
      end else begin
         state <= state_d;
         irq   <= (state_d == PENDING);
         armed <= (state_d == ARMED);

         if (wr_period_c) period_q <= wr_data;

         // A software COMPARE write wins over the periodic advance.
         if (wr_compare_c)             compare_q <= wr_data;
         else if (fire_c && advance_c) compare_q <= compare_q + period_q;

         if (wr_control_c) begin
            enable_q   <= wr_data[0];
            periodic_q <= wr_data[1];
         end else if (fire_c && !advance_c) begin
            enable_q <= 1'b0;
         end

         if (fire_c) match_count <= count;

         overrun <= (overrun && !ovr_clear_c) || ovr_event_c;
      end
   end

endmodule

// File: tb/tb_timer_irq.sv
// Directed bench for timer_irq: one-shot, periodic, wrap, overrun, reset and
// collision scenarios with hand-computed expectations.
module tb_timer_irq;

   logic        clk_clock = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] count = '0;
   logic        wr_en = 1'b0;
   logic [1:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        irq_ack = 1'b0;
   logic        irq;
   logic        overrun;
   logic        armed;
   logic [31:0] match_count;

   int checks = 0;
   int failures = 0;

   timer_irq #(.time_size(32)) dut (
      .clk_clock   (clk_clock),
      .rst         (rst),
      .count       (count),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .irq_ack     (irq_ack),
      .irq         (irq),
      .overrun     (overrun),
      .armed       (armed),
      .match_count (match_count)
   );

   always #5 clk_clock = ~clk_clock;

   task automatic tick();
      @(posedge clk_clock);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; wr_en = 1'b0; irq_ack = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic write(input logic [1:0] a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0b exp=0", irq); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL reset_armed got=%0b exp=0", armed); end
      checks++; if (match_count !== 32'd0) begin failures++; $display("FAIL reset_match got=%0h exp=0", match_count); end
      rst = 1'b1;
      count = 32'd0;
      write(2'd3, 32'h7);
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL addr3_ignored armed got=%0b exp=0", armed); end
   endtask

   task automatic test_oneshot();
      logic exp;
      do_reset();
      count = 32'd90;
      write(2'd0, 32'd100);
      write(2'd2, 32'd1);
      checks++; if (armed !== 1'b1) begin failures++; $display("FAIL oneshot_armed got=%0b exp=1", armed); end
      for (int c = 90; c <= 100; c++) begin
         count = 32'(c);
         tick();
         exp = (c == 100);
         checks++; if (irq !== exp) begin failures++; $display("FAIL oneshot_irq count=%0d got=%0b exp=%0b", c, irq, exp); end
      end
      checks++; if (match_count !== 32'd100) begin failures++; $display("FAIL oneshot_match got=%0d exp=100", match_count); end
      count = 32'd101; irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_ack_irq got=%0b exp=0", irq); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL oneshot_ack_armed got=%0b exp=0", armed); end
      count = 32'd102;
      tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_no_refire got=%0b exp=0", irq); end
   endtask

   task automatic test_periodic();
      logic exp;
      do_reset();
      count = 32'd0;
      write(2'd1, 32'd5);
      write(2'd0, 32'd10);
      write(2'd2, 32'd3);
      for (int c = 1; c <= 24; c++) begin
         count = 32'(c);
         tick();
         exp = (c == 10) || (c == 15) || (c == 20);
         checks++; if (irq !== exp) begin failures++; $display("FAIL periodic_irq count=%0d got=%0b exp=%0b", c, irq, exp); end
         if (exp) begin
            checks++; if (match_count !== 32'(c)) begin failures++; $display("FAIL periodic_match got=%0d exp=%0d", match_count, c); end
         end
         irq_ack = exp;
      end
      irq_ack = 1'b0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL periodic_overrun got=%0b exp=0", overrun); end
   endtask

   task automatic test_wrap();
      logic [31:0] seq [8];
      logic exp;
      seq = '{32'hFFFF_FFFC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
              32'h0, 32'h1, 32'h2, 32'h3};
      do_reset();
      count = 32'hFFFF_FFF0;
      write(2'd0, 32'h2);
      write(2'd2, 32'h1);
      for (int i = 0; i < 7; i++) begin
         count = seq[i];
         tick();
         exp = (seq[i] == 32'h2);
         checks++; if (irq !== exp) begin failures++; $display("FAIL wrap_irq count=%0h got=%0b exp=%0b", seq[i], irq, exp); end
      end
      checks++; if (match_count !== 32'h2) begin failures++; $display("FAIL wrap_match got=%0h exp=2", match_count); end
   endtask

   task automatic test_overrun();
      do_reset();
      count = 32'd0;
      write(2'd1, 32'd3);
      write(2'd0, 32'd20);
      write(2'd2, 32'd3);
      count = 32'd20;
      tick();
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_first got=%0b exp=0", overrun); end
      for (int c = 21; c <= 27; c++) begin
         count = 32'(c);
         tick();
         if (c == 23) begin
            checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%0b exp=1", overrun); end
         end
      end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%0b exp=1", overrun); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL overrun_irq_held got=%0b exp=1", irq); end
      checks++; if (match_count !== 32'd26) begin failures++; $display("FAIL overrun_match got=%0d exp=26", match_count); end
      count = 32'd28;
      write(2'd2, 32'h7);
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%0b exp=0", overrun); end
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL overrun_clear_irq got=%0b exp=1", irq); end
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      checks++; if (armed !== 1'b1) begin failures++; $display("FAIL overrun_ack_armed got=%0b exp=1", armed); end
   endtask

   task automatic test_reset_pending();
      do_reset();
      count = 32'd50;
      write(2'd0, 32'd55);
      write(2'd2, 32'd1);
      count = 32'd55;
      tick();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rstpend_irq_before got=%0b exp=1", irq); end
      rst = 1'b0; wr_en = 1'b1; wr_addr = 2'd2; wr_data = 32'd1; count = 32'd56;
      tick();
      rst = 1'b1; wr_en = 1'b0;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstpend_irq got=%0b exp=0", irq); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL rstpend_overrun got=%0b exp=0", overrun); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL rstpend_armed got=%0b exp=0", armed); end
      checks++; if (match_count !== 32'd0) begin failures++; $display("FAIL rstpend_match got=%0d exp=0", match_count); end
      for (int c = 57; c <= 60; c++) begin
         count = 32'(c);
         tick();
         checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstpend_no_fire count=%0d got=%0b exp=0", c, irq); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      count = 32'd0;
      write(2'd1, 32'd2);
      write(2'd0, 32'd10);
      write(2'd2, 32'd3);
      count = 32'd10;
      tick();
      count = 32'd11;
      tick();
      count = 32'd12; irq_ack = 1'b1;
      tick();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ackfire_irq got=%0b exp=1", irq); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ackfire_overrun got=%0b exp=0", overrun); end
      checks++; if (match_count !== 32'd12) begin failures++; $display("FAIL ackfire_match got=%0d exp=12", match_count); end
      count = 32'd13;
      tick();
      irq_ack = 1'b0;
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ackfire_release got=%0b exp=0", irq); end
      count = 32'd14;
      write(2'd0, 32'd40);
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL cmpwr_fire got=%0b exp=1", irq); end
      checks++; if (match_count !== 32'd14) begin failures++; $display("FAIL cmpwr_match got=%0d exp=14", match_count); end
      count = 32'd15; irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      count = 32'd16;
      tick();
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL cmpwr_no_advance got=%0b exp=0", irq); end
      count = 32'd40;
      tick();
      checks++; if (irq !== 1'b1) begin failures++; $display("FAIL cmpwr_new_compare got=%0b exp=1", irq); end
      count = 32'd41;
      write(2'd2, 32'd0);
      checks++; if (irq !== 1'b0) begin failures++; $display("FAIL disable_irq got=%0b exp=0", irq); end
      checks++; if (armed !== 1'b0) begin failures++; $display("FAIL disable_armed got=%0b exp=0", armed); end
      checks++; if (match_count !== 32'd40) begin failures++; $display("FAIL disable_match got=%0d exp=40", match_count); end
   endtask

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_wrap();
      test_overrun();
      test_reset_pending();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/timer_irq.md
TIMER_IRQ -- requirements
Module: timer_irq

Interface
REQ-001 The block SHALL have parameter time_size, default 32, giving the width of the timer count and of all compare, period and data values.
REQ-002 The block SHALL have port clk_clock, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port count, input, time_size bits: the free-running timer value, same clock domain, wrapping at 2^time_size.
REQ-005 The block SHALL have port wr_en, input, 1 bit: register write strobe, one write per cycle.
REQ-006 The block SHALL have port wr_addr, input, 2 bits: 0 = COMPARE, 1 = PERIOD, 2 = CONTROL, 3 = ignored.
REQ-007 The block SHALL have port wr_data, input, time_size bits: write data.
REQ-008 The block SHALL have port irq_ack, input, 1 bit: interrupt acknowledge, level, sampled each cycle.
REQ-009 The block SHALL have port irq, output, 1 bit: interrupt request, registered.
REQ-010 The block SHALL have port overrun, output, 1 bit: sticky flag for a missed event.
REQ-011 The block SHALL have port armed, output, 1 bit: high when the state is ARMED.
REQ-012 The block SHALL have port match_count, output, time_size bits: count value latched at the last fire.

Function
REQ-013 CONTROL SHALL use bit0 as enable, bit1 as periodic and bit2 as overrun clear; bit2 is write-1-to-clear and is not stored; all other bits are ignored.
REQ-014 The state machine SHALL have three states: IDLE, ARMED and PENDING; irq SHALL be 1 exactly when the state is PENDING.
REQ-015 The fire condition SHALL be: (count - COMPARE) mod 2^time_size has MSB = 0, i.e. count has reached or passed COMPARE within half the range, so wrap-around is tolerated.
REQ-016 IDLE -> ARMED SHALL occur one cycle after a CONTROL write with enable = 1.
REQ-017 ARMED -> PENDING SHALL occur when the fire condition is true in cycle N; irq = 1 and match_count = count(N) SHALL be visible after edge N+1.
REQ-018 On fire with periodic = 1 and PERIOD != 0, COMPARE SHALL become COMPARE + PERIOD, mod 2^time_size, with the carry discarded.
REQ-019 On fire with periodic = 0 or PERIOD = 0, enable SHALL be cleared (one-shot) and COMPARE SHALL be unchanged.
REQ-020 In PENDING, irq_ack = 1 SHALL move the state to ARMED if enable = 1, else to IDLE; irq SHALL fall at the next edge.
REQ-021 In PENDING without ack, a true fire condition SHALL set overrun = 1, update match_count, advance COMPARE per REQ-018, and keep the state PENDING.
REQ-022 In PENDING, ack and a fire condition in the same cycle SHALL keep the state PENDING and update match_count and COMPARE; overrun SHALL NOT be set.
REQ-023 A CONTROL write with enable = 0 SHALL force IDLE from any state at the next edge and drop irq; overrun and match_count SHALL hold.
REQ-024 A COMPARE write in the same cycle as a fire SHALL take precedence over the periodic advance; the fire itself SHALL still take effect.
REQ-025 A CONTROL write setting bit2 SHALL clear overrun; if an overrun event occurs in the same cycle, overrun SHALL end at 1.
REQ-026 Arming while COMPARE is already behind count, within half range, SHALL fire on the first ARMED cycle; this is intended catch-up behaviour.
REQ-027 Writes to PERIOD SHALL take effect for the next advance; writes to wr_addr 3 SHALL have no effect.

Reset
REQ-028 When rst = 0 at a clk_clock edge, the block SHALL go to IDLE with irq = 0, overrun = 0, armed = 0, match_count = 0, COMPARE = 0, PERIOD = 0 and CONTROL = 0.
REQ-029 Reset SHALL override any concurrent write, ack or fire.
REQ-030 Reset asserted while in PENDING SHALL drop irq at that edge.

Verification
REQ-031 One-shot: COMPARE = 100, CONTROL = 1, count ramps from 90 -> irq rises on the edge after count = 100; match_count = 100; ack -> IDLE, armed = 0.
REQ-032 Periodic: COMPARE = 10, PERIOD = 5, CONTROL = 3, ack each event -> irq at count = 10, 15, 20; overrun = 0.
REQ-033 Wrap: time_size = 32, COMPARE = 0x0000_0002, count starts at 0xFFFF_FFFC -> no fire until count = 2; irq on the following edge.
REQ-034 Overrun: PERIOD = 3, periodic, no ack for 7 cycles after the first fire -> overrun = 1, irq held, match_count = last fire count; CONTROL write 0x7 -> overrun = 0.
REQ-035 Reset mid-PENDING: rst = 0 for one cycle while irq = 1 -> all outputs 0 at that edge; no fire afterwards until re-enabled.
REQ-036 Collisions: ack and fire in the same cycle -> irq stays 1 and overrun stays 0; COMPARE write coinciding with a fire -> COMPARE equals the written value.
